pwm_duty_ramp_ctrl: RTL
=======================

// Module: pwm_duty_ramp_ctrl
// PURPOSE
//  Soft-start/soft-stop sequencer for the 100-step PWM generator: accepts a target duty (0..100 %)
//  and slews the PWM duty input toward it in fixed steps at a fixed rate, so motors/LEDs on the
//  Cora board never see a duty jump. Sits between the control/UI logic and the PWM duty port.
//  It also supplies the PWM frequency word, which is held constant.
// PARAMETERS
//  SYS_CLK_FREQ  125_000_000  system clock in Hz; informational, used only for STEP_CLKS default
//  STEP_CLKS     1_250_000    clocks between duty updates (10 ms at 125 MHz); must be >= 2
//  STEP          1            duty change per update, 1..100
//  DUTY_MAX      100          upper clamp for target and duty
//  PWM_FREQ      1000         constant driven on pwm_freq (Hz), must fit 14 bits
// PORTS
//  clk          in   1   system clock, all logic on posedge
//  rstn         in   1   asynchronous active-low reset
//  target       in   7   requested duty in %, sampled only when load=1
//  load         in   1   1-cycle strobe: latch target, start ramp
//  estop        in   1   level: force duty 0 immediately, abort ramp
//  duty         out  7   duty to PWM generator (registered)
//  pwm_freq     out  14  constant PWM_FREQ to PWM generator
//  busy         out  1   1 while ramping (RAMP_UP/RAMP_DOWN)
//  done         out  1   1-cycle pulse when duty reaches latched target
// BEHAVIOUR
//  Reset (rstn=0, async): duty=0, tgt_q=0, tick cnt=0, busy=0, done=0, state=IDLE.
//  pwm_freq = PWM_FREQ at all times, including during reset.
//  Target latch: on load, tgt_q <= min(target, DUTY_MAX); values 101..127 are clamped to 100.
//  Tick counter: 0..STEP_CLKS-1, free-running while busy; tick=1 when cnt==STEP_CLKS-1 (then wraps to 0).
//   Cleared to 0 on load, estop, and whenever busy=0.
//  FSM states IDLE, RAMP_UP, RAMP_DOWN, HOLD:
//   IDLE  : duty=0. load with clamped target>0 -> RAMP_UP. load with target 0 -> done next cycle, stay IDLE.
//   RAMP_UP: on tick duty <= min(duty+STEP, tgt_q). When duty reaches tgt_q -> HOLD, done=1 that cycle.
//   RAMP_DOWN: on tick duty <= max(duty-STEP, tgt_q), using a saturating subtract with no
//    underflow below 0. When duty reaches tgt_q -> HOLD (or IDLE if tgt_q==0), done=1 that cycle.
//   HOLD  : duty constant. load with new target:
//    - greater than duty -> RAMP_UP
//    - less than duty -> RAMP_DOWN
//    - equal to duty -> done pulse next cycle, stay HOLD
//  Retarget mid-ramp: load in RAMP_UP/RAMP_DOWN re-latches tgt_q, restarts the tick count, and
//   re-selects direction from the current duty on the next cycle; no duty change on the load cycle.
//  Latency: first duty change occurs STEP_CLKS clocks after the load cycle. A full ramp of D
//   takes ceil(D/STEP)*STEP_CLKS clocks. done is asserted on the same cycle duty takes its final value.
//  estop=1: next clk, duty=0, tgt_q=0, state=IDLE, busy=0, done=0; load is ignored while estop=1.
//   On estop release, the block stays IDLE until the next load.
//  Simultaneous load+tick: load wins (tick discarded). Simultaneous estop+load: estop wins.
//  Arithmetic is done 8 bits wide internally so duty+STEP cannot overflow before the clamp.
//  All outputs are registered; no combinational path from inputs to outputs.
// TESTING  (bench uses STEP_CLKS=10, STEP=1 unless noted)
//  1 Reset: rstn=0 mid-ramp at duty=37 -> duty=0, busy=0, done=0 asynchronously; pwm_freq=1000.
//  2 Ramp up: load target=5 from IDLE -> duty 1,2,3,4,5 at clocks +10,+20,..,+50; done pulse at +50; busy low after.
//  3 Clamp/step: STEP=7, load target=120 -> tgt_q=100; duty 7,14,..,98,100 (last step saturates); one done pulse.
//  4 Retarget down mid-ramp: ramping to 50 at duty=20, load 10 -> RAMP_DOWN, duty 19..10, done at 10, HOLD.
//  5 Same target: in HOLD at 30, load 30 -> done pulse next cycle, duty unchanged, busy stays 0.
//  6 estop: during ramp at duty=40, estop=1 together with load=80 -> duty=0 next clk, IDLE; load ignored; after release duty stays 0.

Source files
------------

// File: rtl/pwm_duty_ramp_ctrl_if.sv
// Control-side bundle of the duty ramp sequencer: target/load/estop in, duty/frequency/status out.
interface pwm_duty_ramp_ctrl_if;
  logic [6:0]  target;
  logic        load;
  logic        estop;
  logic [6:0]  duty;
  logic [13:0] pwm_freq;
  logic        busy;
  logic        done;

  modport master (
    output target, load, estop,
    input  duty, pwm_freq, busy, done
  );

  modport slave (
    input  target, load, estop,
    output duty, pwm_freq, busy, done
  );
endinterface

// File: rtl/pwm_duty_ramp_ctrl.sv
// Soft-start/soft-stop sequencer: slews the PWM duty toward a latched target in fixed steps at a
// fixed tick rate, with an emergency stop that forces duty to zero.
module pwm_duty_ramp_ctrl #(
  parameter int unsigned SYS_CLK_FREQ = 125_000_000,
  parameter int unsigned STEP_CLKS    = SYS_CLK_FREQ / 100,
  parameter int unsigned STEP         = 1,
  parameter int unsigned DUTY_MAX     = 100,
  parameter int unsigned PWM_FREQ     = 1000
) (
  input logic                  clk,
  input logic                  rstn,
  pwm_duty_ramp_ctrl_if.slave  ctrl
);

  localparam int unsigned CntW    = $clog2(STEP_CLKS);
  localparam logic [6:0]  DutyMax = 7'(DUTY_MAX);
  localparam logic [7:0]  Step8   = 8'(STEP);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StRampUp   = 2'd1;
  localparam logic [1:0] StRampDown = 2'd2;
  localparam logic [1:0] StHold     = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [6:0]      duty_q, duty_d;
  logic [6:0]      tgt_q, tgt_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            tick;
  logic [6:0]      tgt_in;
  logic [7:0]      up_sum, dn_diff;
  logic [6:0]      up_val, dn_val;

  assign tick   = busy_q && (cnt_q == CntW'(STEP_CLKS - 1));
  assign tgt_in = (ctrl.target > DutyMax) ? DutyMax : ctrl.target;

  // 8-bit arithmetic so duty+STEP cannot wrap before the clamp to the target.
  always_comb begin
    up_sum  = {1'b0, duty_q} + Step8;
    dn_diff = ({1'b0, duty_q} >= Step8) ? ({1'b0, duty_q} - Step8) : 8'd0;
    up_val  = (up_sum > {1'b0, tgt_q}) ? tgt_q : up_sum[6:0];
    dn_val  = (dn_diff < {1'b0, tgt_q}) ? tgt_q : dn_diff[6:0];
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    done_d  = 1'b0;

    if (ctrl.estop) begin
      state_d = StIdle;
      duty_d  = 7'd0;
      tgt_d   = 7'd0;
    end else if (ctrl.load) begin
      tgt_d = tgt_in;
      // A load mid-ramp only re-latches; direction is re-chosen on the following cycle.
      if (state_q == StIdle || state_q == StHold) begin
        if (tgt_in > duty_q) begin
          state_d = StRampUp;
        end else if (tgt_in < duty_q) begin
          state_d = StRampDown;
        end else begin
          done_d = 1'b1;
        end
      end
    end else begin
      case (state_q)
        StRampUp: begin
          if (duty_q > tgt_q) begin
            state_d = StRampDown;
          end else if (duty_q == tgt_q) begin
            done_d  = 1'b1;
            state_d = (tgt_q == 7'd0) ? StIdle : StHold;
          end else if (tick) begin
            duty_d = up_val;
            if (up_val == tgt_q) begin
              done_d  = 1'b1;
              state_d = StHold;
            end
          end
        end
        StRampDown: begin
          if (duty_q < tgt_q) begin
            state_d = StRampUp;
          end else if (duty_q == tgt_q) begin
            done_d  = 1'b1;
            state_d = (tgt_q == 7'd0) ? StIdle : StHold;
          end else if (tick) begin
            duty_d = dn_val;
            if (dn_val == tgt_q) begin
              done_d  = 1'b1;
              state_d = (tgt_q == 7'd0) ? StIdle : StHold;
            end
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d == StRampUp) || (state_d == StRampDown);
  end

  always_comb begin
    if (ctrl.estop || ctrl.load || !busy_q) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      duty_q  <= 7'd0;
      tgt_q   <= 7'd0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ctrl.duty     = duty_q;
  assign ctrl.busy     = busy_q;
  assign ctrl.done     = done_q;
  assign ctrl.pwm_freq = 14'(PWM_FREQ);

endmodule
